sha256_w_expander_pipe: RTL and testbench

Parametrised SHA-256 message-schedule expander for the double-SHA256 datapath. It accepts one 512-bit padded block through a valid/ready handshake and streams the schedule words W0..W(ROUNDS-1) to the round datapath, WPB words per beat. A 16-word sliding window computes new words on the fly. The block supports back-pressure, back-to-back blocks, early termination (ROUNDS < 64) and synchronous abort.

---
 rtl/sha256_pkg.sv | 31 +++
 rtl/sha256_w_step.sv | 16 +
 rtl/sha256_w_expander_pipe.sv | 123 ++++++++++++
 tb/tb_sha256_w_expander_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule types, sigma functions and block unpacking.
// Imported by the message-schedule expander and its word-step logic.
package sha256_pkg;

  localparam int W_WIDTH = 32;

  typedef logic [W_WIDTH-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic word_t sigma0_256(word_t x);
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ (x >> 3);
  endfunction

  function automatic word_t sigma1_256(word_t x);
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ (x >> 10);
  endfunction

  // W0 sits in the top 32 bits of the padded block.
  function automatic word_t unpack_word(logic [511:0] b, int i);
    return b[511-32*i -: 32];
  endfunction

endpackage

// File: rtl/sha256_w_step.sv
// One schedule word: s1(w14) + w9 + s0(w1) + w0, modulo 2^32.
// Purely combinational; chained across lanes by the expander.
module sha256_w_step
  import sha256_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] w9_i,
  input  logic [31:0] w14_i,
  output logic [31:0] w_o
);

  assign w_o = sigma1_256(w14_i) + w9_i
             + sigma0_256(w1_i) + w0_i;

endmodule

// File: rtl/sha256_w_expander_pipe.sv
// SHA-256 message-schedule expander, WPB words per beat.
// A 16-word sliding window produces new words on the fly.
module sha256_w_expander_pipe
  import sha256_pkg::*;
#(
  parameter int WPB    = 1,
  parameter int ROUNDS = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [511:0]       block_i,
  input  logic               abort_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [32*WPB-1:0]  out_words_o,
  output logic [5:0]         out_index_o,
  output logic               out_last_o,
  output logic               busy_o
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - WPB);
  localparam logic [5:0] STEP     = 6'(WPB);

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  word_t      win_q [16];
  word_t      win_d [16];
  word_t      nw    [WPB];
  word_t      shf   [16];

  logic run, last;

  assign run  = (state_q == RUN);
  assign last = run && (idx_q == LAST_IDX);

  // Lanes j >= 2 take their s1 argument from lane j-2 of this cycle.
  for (genvar j = 0; j < WPB; j++) begin : g_step
    word_t s1_arg;
    word_t w_new;
    if (j < 2) begin : g_win
      assign s1_arg = win_q[14+j];
    end else begin : g_chain
      assign s1_arg = g_step[j-2].w_new;
    end
    sha256_w_step u_step (
      .w0_i  (win_q[j]),
      .w1_i  (win_q[j+1]),
      .w9_i  (win_q[j+9]),
      .w14_i (s1_arg),
      .w_o   (w_new)
    );
    assign nw[j] = w_new;
    assign out_words_o[32*(WPB-1-j) +: 32] = win_q[j];
  end

  for (genvar i = 0; i < 16; i++) begin : g_shf
    if (i + WPB < 16) begin : g_old
      assign shf[i] = win_q[i+WPB];
    end else begin : g_new
      assign shf[i] = nw[i+WPB-16];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    if (abort_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            for (int i = 0; i < 16; i++)
              win_d[i] = unpack_word(block_i, i);
            state_d = RUN;
          end
        end
        RUN: begin
          if (out_ready_i) begin
            if (last) begin
              idx_d = '0;
              if (in_valid_i) begin
                for (int i = 0; i < 16; i++)
                  win_d[i] = unpack_word(block_i, i);
              end else begin
                state_d = IDLE;
              end
            end else begin
              win_d = shf;
              idx_d = idx_q + STEP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < 16; i++)
        win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
    end
  end

  assign in_ready_o  = rst_ni & ~abort_i
                     & (~run | (last & out_ready_i));
  assign out_valid_o = run;
  assign busy_o      = run;
  assign out_index_o = idx_q;
  assign out_last_o  = last;

endmodule

// File: tb/tb_sha256_w_expander_pipe.sv
// Directed bench: four expander configurations against a
// software schedule model plus hand-computed "abc" words.
module tb_sha256_w_expander_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [511:0] blk;
  logic         inv  [4];
  logic         ordy [4];
  logic         abt  [4];
  logic         irdy [4];
  logic         ov   [4];
  logic         ol   [4];
  logic         bz   [4];
  logic [5:0]   oi   [4];
  logic [31:0]  ow0;
  logic [63:0]  ow1;
  logic [127:0] ow2;
  logic [31:0]  ow3;

  int ncmp = 0;
  int nerr = 0;

  sha256_w_expander_pipe #(.WPB(1), .ROUNDS(64)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inv[0]),
    .in_ready_o(irdy[0]), .block_i(blk), .abort_i(abt[0]),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
    .out_words_o(ow0), .out_index_o(oi[0]),
    .out_last_o(ol[0]), .busy_o(bz[0]));

  sha256_w_expander_pipe #(.WPB(2), .ROUNDS(64)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inv[1]),
    .in_ready_o(irdy[1]), .block_i(blk), .abort_i(abt[1]),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
    .out_words_o(ow1), .out_index_o(oi[1]),
    .out_last_o(ol[1]), .busy_o(bz[1]));

  sha256_w_expander_pipe #(.WPB(4), .ROUNDS(64)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inv[2]),
    .in_ready_o(irdy[2]), .block_i(blk), .abort_i(abt[2]),
    .out_valid_o(ov[2]), .out_ready_i(ordy[2]),
    .out_words_o(ow2), .out_index_o(oi[2]),
    .out_last_o(ol[2]), .busy_o(bz[2]));

  sha256_w_expander_pipe #(.WPB(1), .ROUNDS(61)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inv[3]),
    .in_ready_o(irdy[3]), .block_i(blk), .abort_i(abt[3]),
    .out_valid_o(ov[3]), .out_ready_i(ordy[3]),
    .out_words_o(ow3), .out_index_o(oi[3]),
    .out_last_o(ol[3]), .busy_o(bz[3]));

  int           sel = 0;
  logic         mvalid, mlast, mrdy, mbusy;
  logic [5:0]   midx;
  logic [127:0] mwords;

  always_comb begin
    mvalid = ov[sel];
    mlast  = ol[sel];
    mrdy   = irdy[sel];
    mbusy  = bz[sel];
    midx   = oi[sel];
    mwords = '0;
    case (sel)
      0: mwords = {96'b0, ow0};
      1: mwords = {64'b0, ow1};
      2: mwords = ow2;
      default: mwords = {96'b0, ow3};
    endcase
  end

  logic [31:0] ew [64];

  function automatic logic [31:0] rr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build(input logic [511:0] b);
    for (int i = 0; i < 16; i++) ew[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      ew[i] = ms1(ew[i-2]) + ew[i-7] + ms0(ew[i-15]) + ew[i-16];
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run_block(input int k, input int wpb,
                           input int rounds, input bit stall,
                           input bit b2b, input bit abc,
                           input logic [511:0] nxt);
    int          beats;
    int          eidx;
    bit          held;
    bit          done;
    logic [127:0] hw;
    logic [5:0]  hi;
    logic        hl;
    logic [31:0] w;
    sel = k;
    @(negedge clk);
    inv[k] = 1'b1; ordy[k] = 1'b0;
    #1 chk("in_ready_idle", mrdy, 1);
    @(negedge clk);
    inv[k] = 1'b0;
    #1 chk("first_valid", mvalid, 1);
    beats = 0; eidx = 0; held = 0; done = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      ordy[k] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (held) begin
        chk("stall_words", mwords, hw);
        chk("stall_index", midx, hi);
        chk("stall_last", mlast, hl);
      end
      if (!mvalid) begin
        chk("valid_drop", mvalid, 1);
        done = 1;
      end else if (ordy[k]) begin
        chk("index", midx, eidx[5:0]);
        for (int j = 0; j < wpb; j++) begin
          w = mwords[32*(wpb-1-j) +: 32];
          chk("word", w, ew[eidx+j]);
          if (abc && eidx + j == 16) chk("abc_w16", w, 32'h61626380);
          if (abc && eidx + j == 17) chk("abc_w17", w, 32'h000F0000);
        end
        chk("last", mlast, (eidx == rounds - wpb));
        beats++;
        eidx += wpb;
        held = 0;
        if (mlast) begin
          done = 1;
          if (b2b) begin
            blk = nxt; inv[k] = 1'b1;
            #1 chk("b2b_in_ready", mrdy, 1);
          end
        end
      end else begin
        held = 1; hw = mwords; hi = midx; hl = mlast;
      end
      @(negedge clk);
    end
    if (!done) chk("stream_timeout", 0, 1);
    chk("beat_count", beats, rounds / wpb);
    if (b2b) begin
      inv[k] = 1'b0;
      build(nxt);
      #1;
      chk("b2b_valid", mvalid, 1);
      chk("b2b_index", midx, 0);
      chk("b2b_w0", mwords[32*(wpb-1) +: 32], ew[0]);
      ordy[k] = 1'b1;
      for (int c = 0; c < 100 && mvalid; c++) begin
        @(negedge clk); #1;
      end
      chk("b2b_drain", mvalid, 0);
    end
    ordy[k] = 1'b0;
  endtask

  logic [511:0] abc_blk;
  logic [511:0] blk2;

  initial begin
    abc_blk = {32'h61626380, 448'b0, 32'h00000018};
    for (int i = 0; i < 16; i++)
      blk2[511-32*i -: 32] = 32'h01234567 * (i + 3) ^ 32'hA5A5_0000;
    for (int k = 0; k < 4; k++) begin
      inv[k] = 1'b0; ordy[k] = 1'b0; abt[k] = 1'b0;
    end
    blk = abc_blk;
    rst_n = 1'b0;
    #12;
    sel = 0;
    chk("rst_valid", mvalid, 0);
    chk("rst_busy", mbusy, 0);
    chk("rst_words", mwords, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", mrdy, 1);

    // Mid-stream asynchronous reset drops the stream.
    build(abc_blk);
    @(negedge clk);
    inv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    inv[0] = 1'b0;
    repeat (20) @(negedge clk);
    #1 chk("pre_rst_busy", mbusy, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", mvalid, 0);
    chk("arst_words", mwords, 0);
    chk("arst_index", midx, 0);
    chk("arst_last", mlast, 0);
    chk("arst_busy", mbusy, 0);
    chk("arst_in_ready", mrdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b0;
    #1;
    chk("rel_in_ready", mrdy, 1);
    chk("rel_busy", mbusy, 0);

    build(abc_blk);
    blk = abc_blk;
    run_block(0, 1, 64, 0, 0, 1, '0);
    run_block(1, 2, 64, 0, 1, 1, blk2);
    build(abc_blk);
    blk = abc_blk;
    run_block(2, 4, 64, 1, 0, 1, '0);
    run_block(2, 4, 64, 0, 0, 1, '0);

    // Abort part-way through the ROUNDS=61 stream.
    sel = 3;
    @(negedge clk);
    inv[3] = 1'b1;
    @(negedge clk);
    inv[3] = 1'b0; ordy[3] = 1'b1;
    for (int c = 0; c < 100 && midx != 6'd20; c++) begin
      @(negedge clk); #1;
    end
    chk("abort_reach", midx, 20);
    abt[3] = 1'b1; inv[3] = 1'b1;
    #1 chk("abort_in_ready", mrdy, 0);
    @(negedge clk);
    abt[3] = 1'b0; inv[3] = 1'b0; ordy[3] = 1'b0;
    #1;
    chk("abort_valid", mvalid, 0);
    chk("abort_rdy", mrdy, 1);
    chk("abort_index", midx, 0);
    chk("abort_busy", mbusy, 0);
    run_block(3, 1, 61, 0, 0, 1, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
